decode_regfile: RTL and testbench
=================================

# decode_regfile

Decode-side register file for the Y86-64 core: the read end of the register-write interface driven by the writeback stage. It derives source register IDs from the fetched instruction, returns `valA`/`valB` with same-cycle write bypass, and owns the 15×64-bit register storage written through the `dstE`/`dstM` ports. A handshaked dump engine streams all registers out for trace and debug without stalling the pipeline.

## Interface
- `WIDTH`, 64, register data width
- `NREGS`, 15, architectural registers; ID 0xF means "none"
- `clk`  in  1  system clock, rising edge active
- `rst_n`  in  1  synchronous active-low reset
- `icode`  in  4  instruction code of the instruction in decode
- `rA`, `rB`  in  4  register specifiers from fetch
- `dstE`, `dstM`  in  4  write targets from writeback; 0xF means no write
- `valE`, `valM`  in  WIDTH  write data for `dstE` / `dstM`
- `srcA`, `srcB`  out  4  decoded source IDs
- `valA`, `valB`  out  WIDTH  operand values
- `dump_start`  in  1  request a full register dump
- `dump_busy`  out  1  dump engine active
- `dump_valid`  out  1  `dump_idx`/`dump_data` hold a beat
- `dump_ready`  in  1  consumer accepts beat
- `dump_idx`  out  4  register ID of current beat
- `dump_data`  out  WIDTH  register value of current beat
- `dump_done`  out  1  one-cycle pulse after the final beat

## Operation
- srcA: `rA` for RRMOVQ/CMOVXX, RMMOVQ, OPQ, PUSHQ; RSP (4'h4) for POPQ, RET; else 0xF.
- srcB: `rB` for OPQ, RMMOVQ, MRMOVQ; RSP for PUSHQ, POPQ, CALL, RET; else 0xF.
- Read of ID 0xF returns 0.
- Bypass priority for `valA`/`valB`: `dstM` match → `valM`; else `dstE` match → `valE`; else storage. 0xF never matches.
- Write: on rising edge, reg[dstE] ← valE if dstE ≠ 0xF; reg[dstM] ← valM if dstM ≠ 0xF. If dstE == dstM ≠ 0xF, valM wins (popq %rsp semantics).
- Dump FSM states IDLE, SCAN.
  - IDLE: `dump_start` → SCAN, idx ← 0.
  - SCAN: `dump_valid` = 1; on valid & ready, idx 14 → IDLE with `dump_done` pulse, else idx+1.
  - `dump_start` ignored in SCAN.
- `dump_data` = storage[dump_idx], no bypass; a write to that register in the accepting cycle is not reflected in the accepted beat.
- `dump_idx`/`dump_data` are held stable while `dump_valid` & !`dump_ready`.

## Timing
- srcA/srcB/valA/valB: combinational, zero latency; writes visible via storage from the next cycle.
- Reset (rst_n low at an edge): all registers 0, FSM IDLE, idx 0, `dump_valid`/`dump_busy`/`dump_done` 0. Reset mid-dump aborts with no `dump_done`.
- Dump: first beat valid the cycle after `dump_start`; `dump_busy` = (state == SCAN); minimum 15 cycles of SCAN; `dump_done` high exactly the cycle after the last handshake.
- Dump and pipeline writes/reads proceed concurrently with no interaction.

## Structure
- Shared package `y86_pkg`: icode constants (HALT…POPQ, including RRMOVQ, MRMOVQ, OPQ, CALL, RET, PUSHQ, POPQ), `RSP` = 4'h4, `RNONE` = 4'hF, dump FSM state enum.
- Sub-module `y86_regbank`: storage, two write ports with M-priority, three async read ports (A, B, dump).
- The top level holds the src decode, bypass muxes, and dump FSM.

## Test plan
- Reset, then icode OPQ, rA=2, rB=3 with no writes → srcA=2, srcB=3, valA=valB=0.
- dstE=3, valE=0x55 in cycle N; read rB=3 in cycle N → valB=0x55 (bypass); cycle N+1 with no write → valB=0x55 from storage.
- dstE=dstM=4, valE=0x100, valM=0x200 → next cycle POPQ reads srcA=4, valA=0x200.
- Load reg i=i*0x11, pulse `dump_start` with `dump_ready` toggling 1/0 → 15 beats idx 0..14, data i*0x11, held stable while stalled, `dump_done` single pulse after beat 14.
- Drop `rst_n` at beat 7 → next cycle `dump_valid`=0, `dump_done` never asserts, all regs read 0.
- icode IRMOVQ, HALT, JXX → srcA=srcB=0xF, valA=valB=0 regardless of rA/rB and pending writes.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register IDs and the dump FSM state type.
package y86_pkg;
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RSP   = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic {
      DUMP_IDLE = 1'b0,
      DUMP_SCAN = 1'b1
   } dump_state_t;
endpackage

// File: rtl/y86_regbank.sv
// Register storage with two write ports (M beats E on the same target) and
// three asynchronous read ports; IDs at or above NREGS read as zero.
module y86_regbank
   import y86_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREGS = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       dst_e,
   input  logic [WIDTH-1:0] val_e,
   input  logic [3:0]       dst_m,
   input  logic [WIDTH-1:0] val_m,
   input  logic [3:0]       ra,
   input  logic [3:0]       rb,
   input  logic [3:0]       rd,
   output logic [WIDTH-1:0] rd_a,
   output logic [WIDTH-1:0] rd_b,
   output logic [WIDTH-1:0] rd_d
);
   logic [WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (dst_m == 4'(i))      regs[i] <= val_m;
            else if (dst_e == 4'(i)) regs[i] <= val_e;
         end
      end
   end

   assign rd_a = (ra < 4'(NREGS)) ? regs[ra] : '0;
   assign rd_b = (rb < 4'(NREGS)) ? regs[rb] : '0;
   assign rd_d = (rd < 4'(NREGS)) ? regs[rd] : '0;
endmodule

// File: rtl/decode_regfile.sv
// Decode-side register file: source ID decode, write bypass and a handshaked
// register dump engine that runs alongside normal pipeline traffic.
//
// state     | meaning
// DUMP_IDLE | no dump in progress, waiting for dump_start
// DUMP_SCAN | presenting beat dump_idx, advancing on valid & ready
module decode_regfile
   import y86_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREGS = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       icode,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic [3:0]       dstE,
   input  logic [3:0]       dstM,
   input  logic [WIDTH-1:0] valE,
   input  logic [WIDTH-1:0] valM,
   output logic [3:0]       srcA,
   output logic [3:0]       srcB,
   output logic [WIDTH-1:0] valA,
   output logic [WIDTH-1:0] valB,
   input  logic             dump_start,
   output logic             dump_busy,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [3:0]       dump_idx,
   output logic [WIDTH-1:0] dump_data,
   output logic             dump_done
);
   dump_state_t      state;
   logic [3:0]       idx;
   logic             done;
   logic [WIDTH-1:0] rd_a, rd_b;

   always_comb begin
      srcA = RNONE;
      unique case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
         I_POPQ, I_RET:                      srcA = RSP;
         default:                            srcA = RNONE;
      endcase
   end

   always_comb begin
      srcB = RNONE;
      unique case (icode)
         I_OPQ, I_RMMOVQ, I_MRMOVQ:       srcB = rB;
         I_PUSHQ, I_POPQ, I_CALL, I_RET:  srcB = RSP;
         default:                         srcB = RNONE;
      endcase
   end

   y86_regbank #(.WIDTH(WIDTH), .NREGS(NREGS)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .dst_e (dstE),
      .val_e (valE),
      .dst_m (dstM),
      .val_m (valM),
      .ra    (srcA),
      .rb    (srcB),
      .rd    (idx),
      .rd_a  (rd_a),
      .rd_b  (rd_b),
      .rd_d  (dump_data)
   );

   // RNONE on the source side never matches, so a "none" write is never bypassed.
   always_comb begin
      valA = rd_a;
      if (srcA != RNONE && srcA == dstM)      valA = valM;
      else if (srcA != RNONE && srcA == dstE) valA = valE;
   end

   always_comb begin
      valB = rd_b;
      if (srcB != RNONE && srcB == dstM)      valB = valM;
      else if (srcB != RNONE && srcB == dstE) valB = valE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= DUMP_IDLE;
         idx   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            DUMP_IDLE: begin
               if (dump_start) begin
                  state <= DUMP_SCAN;
                  idx   <= '0;
               end
            end
            DUMP_SCAN: begin
               if (dump_ready) begin
                  if (idx == 4'(NREGS - 1)) begin
                     state <= DUMP_IDLE;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            default: state <= DUMP_IDLE;
         endcase
      end
   end

   assign dump_busy  = (state == DUMP_SCAN);
   assign dump_valid = (state == DUMP_SCAN);
   assign dump_idx   = idx;
   assign dump_done  = done;
endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: vector table for decode/bypass/write,
// hand sequences for the dump handshake and reset during a dump.
module tb_decode_regfile;
   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    icode, rA, rB, dstE, dstM;
   logic [W-1:0]  valE, valM;
   logic [3:0]    srcA, srcB;
   logic [W-1:0]  valA, valB;
   logic          dump_start, dump_busy, dump_valid, dump_ready, dump_done;
   logic [3:0]    dump_idx;
   logic [W-1:0]  dump_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode_regfile #(.WIDTH(W), .NREGS(15)) dut (
      .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB),
      .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
      .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
      .dump_done(dump_done)
   );

   typedef struct {
      logic [3:0]   icode, rA, rB, dstE, dstM;
      logic [W-1:0] valE, valM;
      logic [3:0]   e_srcA, e_srcB;
      logic [W-1:0] e_valA, e_valB;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      icode = 4'h1; rA = 4'hF; rB = 4'hF;
      dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
   endtask

   initial begin
      int cyc, exp_i, dones;
      logic tog;

      //            icode  rA     rB     dstE   dstM   valE     valM     srcA   srcB   valA     valB
      vecs[0]  = '{4'h6, 4'h2, 4'h3, 4'hF, 4'hF, 64'h0,   64'h0,   4'h2, 4'h3, 64'h0,   64'h0};
      vecs[1]  = '{4'h6, 4'h2, 4'h3, 4'h3, 4'hF, 64'h55,  64'h0,   4'h2, 4'h3, 64'h0,   64'h55};
      vecs[2]  = '{4'h6, 4'h2, 4'h3, 4'hF, 4'hF, 64'h0,   64'h0,   4'h2, 4'h3, 64'h0,   64'h55};
      vecs[3]  = '{4'h3, 4'h4, 4'h5, 4'h4, 4'h4, 64'h100, 64'h200, 4'hF, 4'hF, 64'h0,   64'h0};
      vecs[4]  = '{4'hB, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'h0,   4'h4, 4'h4, 64'h200, 64'h200};
      vecs[5]  = '{4'hA, 4'h3, 4'hF, 4'h3, 4'h3, 64'h66,  64'h77,  4'h3, 4'h4, 64'h77,  64'h200};
      vecs[6]  = '{4'h2, 4'h3, 4'h1, 4'hF, 4'hF, 64'h0,   64'h0,   4'h3, 4'hF, 64'h77,  64'h0};
      vecs[7]  = '{4'h0, 4'h3, 4'h4, 4'h3, 4'hF, 64'h1,   64'h0,   4'hF, 4'hF, 64'h0,   64'h0};
      vecs[8]  = '{4'h7, 4'h3, 4'h4, 4'hF, 4'h4, 64'h0,   64'h2,   4'hF, 4'hF, 64'h0,   64'h0};
      vecs[9]  = '{4'h4, 4'h3, 4'h4, 4'hF, 4'hF, 64'h0,   64'h0,   4'h3, 4'h4, 64'h1,   64'h2};
      vecs[10] = '{4'h5, 4'h3, 4'h4, 4'h4, 4'hF, 64'h9,   64'h0,   4'hF, 4'h4, 64'h0,   64'h9};
      vecs[11] = '{4'h8, 4'h3, 4'h0, 4'hF, 4'hF, 64'h0,   64'h0,   4'hF, 4'h4, 64'h0,   64'h9};
      vecs[12] = '{4'h9, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'h0,   4'h4, 4'h4, 64'h9,   64'h9};
      vecs[13] = '{4'h1, 4'h3, 4'h4, 4'hF, 4'hF, 64'h0,   64'h0,   4'hF, 4'hF, 64'h0,   64'h0};

      idle_inputs();
      rst_n = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 64'(dump_valid), 64'h0);
      chk("rst_busy",  64'(dump_busy),  64'h0);
      chk("rst_done",  64'(dump_done),  64'h0);
      chk("rst_idx",   64'(dump_idx),   64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 14; v++) begin
         icode = vecs[v].icode; rA = vecs[v].rA; rB = vecs[v].rB;
         dstE = vecs[v].dstE; dstM = vecs[v].dstM;
         valE = vecs[v].valE; valM = vecs[v].valM;
         #1;
         chk($sformatf("v%0d_srcA", v), 64'(srcA), 64'(vecs[v].e_srcA));
         chk($sformatf("v%0d_srcB", v), 64'(srcB), 64'(vecs[v].e_srcB));
         chk($sformatf("v%0d_valA", v), valA, vecs[v].e_valA);
         chk($sformatf("v%0d_valB", v), valB, vecs[v].e_valB);
         @(negedge clk);
      end

      // load reg i = i*0x11
      for (int i = 0; i < 15; i++) begin
         idle_inputs();
         dstE = 4'(i); valE = 64'(i * 'h11);
         @(negedge clk);
      end
      idle_inputs();

      // dump with ready toggling 1/0
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      exp_i = 0; cyc = 0; tog = 1'b1;
      while (exp_i < 15 && cyc < 100) begin
         dump_ready = tog;
         tog = ~tog;
         #1;
         chk("dump_valid", 64'(dump_valid), 64'h1);
         chk("dump_busy",  64'(dump_busy),  64'h1);
         chk("dump_idx",   64'(dump_idx),   64'(exp_i));
         chk("dump_data",  dump_data,       64'(exp_i * 'h11));
         chk("dump_done_early", 64'(dump_done), 64'h0);
         if (dump_ready) exp_i++;
         cyc++;
         @(negedge clk);
      end
      chk("dump_cycle_budget", 64'(exp_i), 64'd15);
      dump_ready = 1'b0;
      #1;
      chk("dump_done_pulse", 64'(dump_done),  64'h1);
      chk("dump_end_valid",  64'(dump_valid), 64'h0);
      chk("dump_end_busy",   64'(dump_busy),  64'h0);
      @(negedge clk);
      #1;
      chk("dump_done_single", 64'(dump_done), 64'h0);
      @(negedge clk);

      // reset during a dump at beat 7
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      dump_ready = 1'b1;
      cyc = 0;
      #1;
      while (dump_idx != 4'd7 && cyc < 40) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk("abort_reached_beat7", 64'(dump_idx), 64'd7);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_valid", 64'(dump_valid), 64'h0);
      chk("abort_busy",  64'(dump_busy),  64'h0);
      chk("abort_idx",   64'(dump_idx),   64'h0);
      dones = 0;
      if (dump_done) dones++;
      @(negedge clk);
      rst_n = 1'b1;
      dump_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (dump_done) dones++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(dones), 64'd0);

      for (int i = 0; i < 15; i++) begin
         idle_inputs();
         icode = 4'h6; rA = 4'(i); rB = 4'(i);
         #1;
         chk($sformatf("abort_reg%0d_A", i), valA, 64'h0);
         chk($sformatf("abort_reg%0d_B", i), valB, 64'h0);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
